// File: rtl/asic_rr3_mux_if.sv
// Bus bundle for the 3:1 packet arbiter/mux: three request channels in, one
// registered beat stream out, plus the one-hot grant for an external and-or select.
interface asic_rr3_mux_if #(
    parameter int DW = 8
) ();
    logic [2:0]      in_valid;
    logic [3*DW-1:0] in_data;
    logic [2:0]      in_last;
    logic [2:0]      in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_ready;
    logic [2:0]      sel;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, sel
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, sel
    );
endinterface

// File: rtl/asic_rr3_mux.sv
// 3:1 round-robin packet arbiter/mux: a grant is held for a whole packet, and
// the output beat register gives one beat per cycle under downstream backpressure.
module asic_rr3_mux #(
    parameter     PROP = "DEFAULT",
    parameter int DW   = 8
) (
    input  logic            clk,
    input  logic            reset,
    asic_rr3_mux_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [2:0]    sel_q, sel_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;

    logic [2:0]    in_ready_s;
    logic          xfer_s;
    logic          beat_last_s;
    logic [DW-1:0] beat_data_s;

    // PROP is a target hint only and deliberately selects nothing.
    if (PROP == "") begin : g_prop_unset
    end

    // First requester in rotating order starting at ptr.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [2:0] pick;
        pick = 3'b000;
        case (ptr)
            2'd1: begin
                if (req[1])      pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
                else             pick = 3'b000;
            end
            2'd2: begin
                if (req[2])      pick = 3'b100;
                else if (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else             pick = 3'b000;
            end
            default: begin
                if (req[0])      pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else             pick = 3'b000;
            end
        endcase
        return pick;
    endfunction

    function automatic logic [1:0] ptr_after(input logic [2:0] grant);
        logic [1:0] nxt;
        case (grant)
            3'b001:  nxt = 2'd1;
            3'b010:  nxt = 2'd2;
            3'b100:  nxt = 2'd0;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    // Accept path: only the granted leg may see ready, and only when the output register can take a beat.
    always_comb begin
        in_ready_s = 3'b000;
        if (state_q == ST_GRANT) begin
            in_ready_s = sel_q & {3{(~out_valid_q) | bus.out_ready}};
        end else begin
            in_ready_s = 3'b000;
        end
        xfer_s      = |(bus.in_valid & in_ready_s);
        beat_last_s = |(bus.in_last & sel_q);
        beat_data_s = ({DW{sel_q[0]}} & bus.in_data[0*DW +: DW])
                    | ({DW{sel_q[1]}} & bus.in_data[1*DW +: DW])
                    | ({DW{sel_q[2]}} & bus.in_data[2*DW +: DW]);
    end

    // Arbitration FSM next state: grant is sticky until the last beat transfers.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.in_valid) begin
                    state_d = ST_GRANT;
                    sel_d   = rr_pick(bus.in_valid, ptr_q);
                end else begin
                    sel_d   = 3'b000;
                end
            end
            ST_GRANT: begin
                if (xfer_s && beat_last_s) begin
                    state_d = ST_IDLE;
                    sel_d   = 3'b000;
                    ptr_d   = ptr_after(sel_q);
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = 3'b000;
            end
        endcase
    end

    // Output beat register: load on transfer, drop valid once drained, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = beat_data_s;
            out_last_d  = beat_last_s;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset wins over any transfer on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            sel_q       <= 3'b000;
            out_valid_q <= 1'b0;
            out_data_q  <= {DW{1'b0}};
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.sel       = sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

endmodule
